mt_rollback_ctrl: RTL and testbench

MT_ROLLBACK_CTRL -- requirements
Module: mt_rollback_ctrl

---
 rtl/mt_rollback_ctrl_if.sv | 39 +++
 rtl/mt_rollback_ctrl.sv | 155 +++++++++++++++
 tb/tb_mt_rollback_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mt_rollback_ctrl_if.sv
// Restore-path bundle of the rollback controller: mispredict requests, AMT read
// port and map-table restore write port. The controller uses `master`, the environment uses `slave`.
interface mt_rollback_ctrl_if #(
    parameter int MT_ENTRY     = 32,
    parameter int THREAD_NUM   = 2,
    parameter int COPY_PER_CYC = 4,
    parameter int TAG_W        = 6
);
    localparam int GRP_N = MT_ENTRY / COPY_PER_CYC;
    localparam int GRP_W = (GRP_N > 1) ? $clog2(GRP_N) : 1;
    localparam int IDX_W = (MT_ENTRY > 1) ? $clog2(MT_ENTRY) : 1;
    localparam int THR_W = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

    logic [THREAD_NUM-1:0]         rollback_i;
    logic                          amt_rd_en_o;
    logic [GRP_W-1:0]              amt_rd_grp_o;
    logic [THR_W-1:0]              amt_rd_thread_o;
    logic [COPY_PER_CYC*TAG_W-1:0] amt_rd_tag_i;
    logic [COPY_PER_CYC-1:0]       mt_wr_en_o;
    logic [COPY_PER_CYC*IDX_W-1:0] mt_wr_idx_o;
    logic [COPY_PER_CYC*TAG_W-1:0] mt_wr_tag_o;
    logic [THR_W-1:0]              mt_wr_thread_o;
    logic [THREAD_NUM-1:0]         dp_stall_o;
    logic                          done_o;

    modport master (
        input  rollback_i, amt_rd_tag_i,
        output amt_rd_en_o, amt_rd_grp_o, amt_rd_thread_o,
               mt_wr_en_o, mt_wr_idx_o, mt_wr_tag_o, mt_wr_thread_o,
               dp_stall_o, done_o
    );

    modport slave (
        output rollback_i, amt_rd_tag_i,
        input  amt_rd_en_o, amt_rd_grp_o, amt_rd_thread_o,
               mt_wr_en_o, mt_wr_idx_o, mt_wr_tag_o, mt_wr_thread_o,
               dp_stall_o, done_o
    );
endinterface

// File: rtl/mt_rollback_ctrl.sv
// Map-table rollback controller: restores a thread's speculative map table from the AMT,
// COPY_PER_CYC entries per cycle. Define MT_RB_PERF_CNT_EN to add restore/stall counters.
module mt_rollback_ctrl #(
    parameter int MT_ENTRY     = 32,
    parameter int THREAD_NUM   = 2,
    parameter int COPY_PER_CYC = 4,
    parameter int TAG_W        = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    mt_rollback_ctrl_if.master bus
`ifdef MT_RB_PERF_CNT_EN
    ,
    output logic [15:0] rb_cnt_o,
    output logic [15:0] stall_cyc_o
`endif
);
    localparam int GRP_N = MT_ENTRY / COPY_PER_CYC;
    localparam int GRP_W = (GRP_N > 1) ? $clog2(GRP_N) : 1;
    localparam int IDX_W = (MT_ENTRY > 1) ? $clog2(MT_ENTRY) : 1;
    localparam int THR_W = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, COPY, LAST} state_e;

    state_e                state_q, state_d;
    logic [THR_W-1:0]      active_q, active_d;
    logic [THREAD_NUM-1:0] pending_q, pending_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic                  wr_vld_q;
    logic [GRP_W-1:0]      wr_grp_q;

    logic                  busy;
    logic [THREAD_NUM-1:0] active_oh;
    logic [THREAD_NUM-1:0] others;
    logic [THREAD_NUM-1:0] merged;
    logic [THR_W-1:0]      sel;

    function automatic logic [THR_W-1:0] lowest(input logic [THREAD_NUM-1:0] v);
        lowest = '0;
        for (int i = THREAD_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest = THR_W'(i);
        end
    endfunction

    function automatic logic [THREAD_NUM-1:0] onehot(input logic [THR_W-1:0] t);
        onehot    = '0;
        onehot[t] = 1'b1;
    endfunction

    assign busy      = (state_q != IDLE);
    assign active_oh = busy ? onehot(active_q) : '0;
    // A request from the thread being restored is dropped: the restore already targets committed state.
    assign others    = bus.rollback_i & ~active_oh;
    assign merged    = pending_q | others;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        grp_d     = grp_q;
        sel       = '0;
        case (state_q)
            IDLE: begin
                if (|bus.rollback_i) begin
                    sel       = lowest(bus.rollback_i);
                    active_d  = sel;
                    pending_d = pending_q | (bus.rollback_i & ~onehot(sel));
                    state_d   = FLUSH;
                end
            end
            FLUSH: begin
                pending_d = merged;
                grp_d     = '0;
                state_d   = COPY;
            end
            COPY: begin
                pending_d = merged;
                if (grp_q == GRP_W'(GRP_N - 1)) begin
                    grp_d   = '0;
                    state_d = LAST;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            LAST: begin
                // Chain straight into the next pending thread so there is no IDLE bubble.
                if (|merged) begin
                    sel       = lowest(merged);
                    active_d  = sel;
                    pending_d = merged & ~onehot(sel);
                    state_d   = FLUSH;
                end else begin
                    pending_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            active_q  <= '0;
            pending_q <= '0;
            grp_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_grp_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            grp_q     <= grp_d;
            wr_vld_q  <= (state_q == COPY);
            wr_grp_q  <= grp_q;
        end
    end

    assign bus.amt_rd_en_o     = (state_q == COPY);
    assign bus.amt_rd_grp_o    = (state_q == COPY) ? grp_q : '0;
    assign bus.amt_rd_thread_o = (state_q == COPY) ? active_q : '0;

    // AMT data arrives one cycle after the read, aligned with the registered write slot.
    assign bus.mt_wr_en_o     = {COPY_PER_CYC{wr_vld_q}};
    assign bus.mt_wr_thread_o = wr_vld_q ? active_q : '0;

    for (genvar k = 0; k < COPY_PER_CYC; k++) begin : g_lane
        assign bus.mt_wr_idx_o[k*IDX_W +: IDX_W] =
            wr_vld_q ? IDX_W'(int'(wr_grp_q) * COPY_PER_CYC + k) : '0;
        assign bus.mt_wr_tag_o[k*TAG_W +: TAG_W] =
            wr_vld_q ? bus.amt_rd_tag_i[k*TAG_W +: TAG_W] : '0;
    end

    assign bus.done_o     = (state_q == LAST);
    assign bus.dp_stall_o = bus.rollback_i | pending_q | active_oh;

`ifdef MT_RB_PERF_CNT_EN
    logic [15:0] rb_cnt_q, stall_cyc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rb_cnt_q    <= '0;
            stall_cyc_q <= '0;
        end else begin
            if ((state_q == LAST) && (rb_cnt_q != 16'hFFFF)) rb_cnt_q <= rb_cnt_q + 16'd1;
            if ((|bus.dp_stall_o) && (stall_cyc_q != 16'hFFFF)) stall_cyc_q <= stall_cyc_q + 16'd1;
        end
    end

    assign rb_cnt_o    = rb_cnt_q;
    assign stall_cyc_o = stall_cyc_q;
`endif
endmodule

// File: tb/tb_mt_rollback_ctrl.sv
// Bench for mt_rollback_ctrl: cycle-offset reference model compared every cycle,
// plus hand-computed literal expectations for the directed sequences.
module tb_mt_rollback_ctrl;
    localparam int MT_ENTRY     = 32;
    localparam int THREAD_NUM   = 2;
    localparam int COPY_PER_CYC = 4;
    localparam int TAG_W        = 6;
    localparam int G            = MT_ENTRY / COPY_PER_CYC;
    localparam int IDX_W        = 5;

    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    mt_rollback_ctrl_if #(
        .MT_ENTRY(MT_ENTRY), .THREAD_NUM(THREAD_NUM),
        .COPY_PER_CYC(COPY_PER_CYC), .TAG_W(TAG_W)
    ) bus ();

`ifdef MT_RB_PERF_CNT_EN
    logic [15:0] rb_cnt, stall_cyc;
`endif

    mt_rollback_ctrl #(
        .MT_ENTRY(MT_ENTRY), .THREAD_NUM(THREAD_NUM),
        .COPY_PER_CYC(COPY_PER_CYC), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus(bus)
`ifdef MT_RB_PERF_CNT_EN
        ,
        .rb_cnt_o(rb_cnt),
        .stall_cyc_o(stall_cyc)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d, t=%0t): got %0h, expected %0h", name, cyc, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Committed (AMT) contents: thread 0 holds 32+idx, thread 1 holds 16+idx.
    function automatic logic [TAG_W-1:0] amt_val(input int thr, input int idx);
        return (thr == 0) ? TAG_W'(32 + idx) : TAG_W'(16 + idx);
    endfunction

    // AMT responder: data for a read appears in the following cycle.
    bit rd_seen = 1'b0;
    int rd_grp  = 0;
    int rd_thr  = 0;
    always @(negedge clk) begin
        rd_seen = (bus.amt_rd_en_o === 1'b1);
        rd_grp  = int'(bus.amt_rd_grp_o);
        rd_thr  = int'(bus.amt_rd_thread_o);
    end
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < COPY_PER_CYC; k++)
            bus.amt_rd_tag_i[k*TAG_W +: TAG_W] = rd_seen ? amt_val(rd_thr, rd_grp * COPY_PER_CYC + k) : '0;
    end

    // Reference model: m_k counts cycles since the thread's FLUSH cycle (k=0);
    // reads at k=1..G, writes at k=2..G+1, done at k=G+1.
    bit                    m_busy = 1'b0;
    int                    m_thr  = 0;
    int                    m_k    = 0;
    logic [THREAD_NUM-1:0] m_pend = '0;

    function automatic int lowest_of(input logic [THREAD_NUM-1:0] v);
        for (int i = 0; i < THREAD_NUM; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [THREAD_NUM-1:0] rb;
        logic [THREAD_NUM-1:0] mine;
        rb = bus.rollback_i;
        if (!rst_i) begin
            m_busy = 1'b0; m_thr = 0; m_k = 0; m_pend = '0;
        end else if (!m_busy) begin
            if (|rb) begin
                m_thr  = lowest_of(rb);
                mine   = '0;
                mine[m_thr] = 1'b1;
                m_pend = m_pend | (rb & ~mine);
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else begin
            mine   = '0;
            mine[m_thr] = 1'b1;
            m_pend = m_pend | (rb & ~mine);
            if (m_k == G + 1) begin
                if (|m_pend) begin
                    m_thr = lowest_of(m_pend);
                    m_pend[m_thr] = 1'b0;
                    m_k = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit                    rd, wr;
            logic [THREAD_NUM-1:0] stall;
            int                    idx;
            rd    = m_busy && (m_k >= 1) && (m_k <= G);
            wr    = m_busy && (m_k >= 2) && (m_k <= G + 1);
            stall = bus.rollback_i | m_pend;
            if (m_busy) stall[m_thr] = 1'b1;
            check("model rd_en", bus.amt_rd_en_o, rd);
            check("model rd_grp", bus.amt_rd_grp_o, rd ? m_k - 1 : 0);
            check("model rd_thread", bus.amt_rd_thread_o, rd ? m_thr : 0);
            check("model wr_en", bus.mt_wr_en_o, wr ? 4'hF : 4'h0);
            check("model wr_thread", bus.mt_wr_thread_o, wr ? m_thr : 0);
            check("model done", bus.done_o, m_busy && (m_k == G + 1));
            check("model dp_stall", bus.dp_stall_o, stall);
            for (int k = 0; k < COPY_PER_CYC; k++) begin
                idx = wr ? (m_k - 2) * COPY_PER_CYC + k : 0;
                check("model wr_idx", bus.mt_wr_idx_o[k*IDX_W +: IDX_W], idx);
                check("model wr_tag", bus.mt_wr_tag_o[k*TAG_W +: TAG_W], wr ? amt_val(m_thr, idx) : 0);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b0;
        bus.rollback_i = '0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        @(negedge clk);
        check("reset rd_en", bus.amt_rd_en_o, 0);
        check("reset wr_en", bus.mt_wr_en_o, 0);
        check("reset wr_idx", bus.mt_wr_idx_o, 0);
        check("reset dp_stall", bus.dp_stall_o, 0);
        check("reset done", bus.done_o, 0);
        tick();
        cyc = 0;
    endtask

    initial begin
        bus.rollback_i = '0;

        // Single thread-0 restore.
        do_reset();
        bus.rollback_i = 2'b01;
        while (cyc <= 12) begin
            @(negedge clk);
            if (cyc == 0) check("t1 stall on request", bus.dp_stall_o, 2'b01);
            if (cyc == 1) check("t1 flush no read", bus.amt_rd_en_o, 0);
            if (cyc == 1) check("t1 flush no write", bus.mt_wr_en_o, 0);
            if (cyc >= 2 && cyc <= 9) check("t1 rd_grp", bus.amt_rd_grp_o, cyc - 2);
            if (cyc == 3) check("t1 first idx lane0", bus.mt_wr_idx_o[0 +: IDX_W], 0);
            if (cyc == 3) check("t1 first tag lane0", bus.mt_wr_tag_o[0 +: TAG_W], 32);
            if (cyc == 10) check("t1 last idx lane3", bus.mt_wr_idx_o[3*IDX_W +: IDX_W], 31);
            if (cyc == 10) check("t1 last tag lane3", bus.mt_wr_tag_o[3*TAG_W +: TAG_W], 63);
            if (cyc == 10) check("t1 done", bus.done_o, 1);
            if (cyc == 11) check("t1 stall released", bus.dp_stall_o, 2'b00);
            if (cyc == 11) check("t1 no write after done", bus.mt_wr_en_o, 0);
            tick();
            bus.rollback_i = '0;
        end

        // Simultaneous requests: thread 0 then thread 1 back to back.
        do_reset();
        bus.rollback_i = 2'b11;
        while (cyc <= 22) begin
            @(negedge clk);
            if (cyc <= 20) check("t2 stall thread1", bus.dp_stall_o[1], 1);
            if (cyc == 10 || cyc == 20) check("t2 done", bus.done_o, 1);
            if (cyc == 11) check("t2 flush thread1", bus.amt_rd_en_o, 0);
            if (cyc == 11) check("t2 stall only thread1", bus.dp_stall_o, 2'b10);
            if (cyc == 12) check("t2 rd_thread", bus.amt_rd_thread_o, 1);
            if (cyc == 13) check("t2 wr_thread", bus.mt_wr_thread_o, 1);
            if (cyc == 13) check("t2 tag thread1 lane0", bus.mt_wr_tag_o[0 +: TAG_W], 16);
            if (cyc == 21) check("t2 stall released", bus.dp_stall_o, 2'b00);
`ifdef MT_RB_PERF_CNT_EN
            if (cyc == 22) check("t2 rb_cnt", rb_cnt, 2);
            if (cyc == 22) check("t2 stall_cyc", stall_cyc, 21);
`endif
            tick();
            bus.rollback_i = '0;
        end

        // Active thread re-requests mid-restore: ignored.
        do_reset();
        bus.rollback_i = 2'b01;
        while (cyc <= 25) begin
            @(negedge clk);
            if (cyc == 5) check("t3 stall on repeat", bus.dp_stall_o, 2'b01);
            if (cyc == 10) check("t3 done", bus.done_o, 1);
            if (cyc >= 11) check("t3 no second done", bus.done_o, 0);
            if (cyc >= 11) check("t3 no second read", bus.amt_rd_en_o, 0);
            tick();
            bus.rollback_i = (cyc == 5) ? 2'b01 : 2'b00;
        end

        // Reset mid-COPY with thread 1 pending.
        do_reset();
        bus.rollback_i = 2'b11;
        while (cyc <= 25) begin
            @(negedge clk);
            if (cyc == 6) check("t4 writing before reset", bus.mt_wr_en_o, 4'hF);
            if (cyc >= 7) check("t4 no writes", bus.mt_wr_en_o, 0);
            if (cyc >= 7) check("t4 stall cleared", bus.dp_stall_o, 0);
            if (cyc >= 7) check("t4 no done", bus.done_o, 0);
            tick();
            bus.rollback_i = '0;
            rst_i = (cyc == 6) ? 1'b0 : 1'b1;
        end

        // Thread 1 first; thread 0 requests during thread 1's final cycle.
        do_reset();
        bus.rollback_i = 2'b10;
        while (cyc <= 22) begin
            @(negedge clk);
            if (cyc == 10) check("t5 done thread1", bus.done_o, 1);
            if (cyc == 10) check("t5 stall both", bus.dp_stall_o, 2'b11);
            if (cyc == 11) check("t5 no gap stall", bus.dp_stall_o, 2'b01);
            if (cyc == 12) check("t5 rd_en thread0", bus.amt_rd_en_o, 1);
            if (cyc == 12) check("t5 rd_thread", bus.amt_rd_thread_o, 0);
            if (cyc == 20) check("t5 done thread0", bus.done_o, 1);
            tick();
            bus.rollback_i = (cyc == 10) ? 2'b01 : 2'b00;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
